// File: rtl/cell_updown_counter.sv
// rtl/cell_updown_counter.sv - up/down counter with load, wrap/saturate, built from gate cells
// Next-state logic is composed only of the primitive cells below; the count lives in one flop bank.

module cell_not (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module cell_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module cell_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module cell_and_not (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & ~b;
endmodule

module cell_or_4bit (
    input  logic [3:0] a,
    output logic       y
);
    assign y = a[0] | a[1] | a[2] | a[3];
endmodule

module cell_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    logic a_nb;
    logic b_na;

    cell_and_not u_anb (.a(a), .b(b), .y(a_nb));
    cell_and_not u_bna (.a(b), .b(a), .y(b_na));
    cell_or      u_or  (.a(a_nb), .b(b_na), .y(y));
endmodule

module cell_mux2 (
    input  logic s,
    input  logic a0,
    input  logic a1,
    output logic y
);
    logic p0;
    logic p1;

    cell_and_not u_p0 (.a(a0), .b(s), .y(p0));
    cell_and     u_p1 (.a(a1), .b(s), .y(p1));
    cell_or      u_or (.a(p0), .b(p1), .y(y));
endmodule

// One up/down half-adder stage: sum toggles on carry-in; the carry (or borrow when dn=1) propagates
// through a bit that is 1 when counting up, 0 when counting down.
module cell_ud_stage (
    input  logic q,
    input  logic dn,
    input  logic ci,
    output logic s,
    output logic co
);
    logic prop;

    cell_xor u_sum  (.a(q), .b(ci), .y(s));
    cell_xor u_prop (.a(q), .b(dn), .y(prop));
    cell_and u_co   (.a(prop), .b(ci), .y(co));
endmodule

module cell_ud_chain #(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    input  logic         dn,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic c0;

    cell_ud_stage u_stage (.q(q[0]), .dn(dn), .ci(ci), .s(s[0]), .co(c0));

    generate
        if (N == 1) begin : g_last
            assign co = c0;
        end else begin : g_rest
            cell_ud_chain #(.N(N-1)) u_rest (
                .q  (q[N-1:1]),
                .dn (dn),
                .ci (c0),
                .s  (s[N-1:1]),
                .co (co)
            );
        end
    endgenerate
endmodule

// OR reduction: 4-input cells at the leaves, 2-input cells above them, split on 4-bit group boundaries.
module cell_or_tree #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    output logic         y
);
    localparam int NG = (N + 3) / 4;
    localparam int LO = 4 * (NG / 2);

    generate
        if (N <= 4) begin : g_leaf
            logic [3:0] pad;
            for (genvar k = 0; k < 4; k++) begin : g_pad
                if (k < N) begin : g_bit
                    assign pad[k] = a[k];
                end else begin : g_zero
                    assign pad[k] = 1'b0;
                end
            end
            cell_or_4bit u_or4 (.a(pad), .y(y));
        end else begin : g_node
            logic y_lo;
            logic y_hi;

            cell_or_tree #(.N(LO))   u_lo (.a(a[LO-1:0]), .y(y_lo));
            cell_or_tree #(.N(N-LO)) u_hi (.a(a[N-1:LO]), .y(y_hi));
            cell_or                  u_or (.a(y_lo), .b(y_hi), .y(y));
        end
    endgenerate
endmodule

module cell_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);
    localparam logic SAT_EN = (SATURATE != 0);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] adv;
    logic [WIDTH-1:0] nxt;
    logic             dn;
    logic             wrap;
    logic             sat_hold;
    logic             any_one;
    logic             any_zero;
    logic             is_zero;
    logic             is_ones;
    logic             at_limit;
    logic             lim_nl;

    cell_not u_dn (.a(up), .y(dn));

    // Carry-out of the chain means this step would wrap past the range limit.
    cell_ud_chain #(.N(WIDTH)) u_chain (
        .q  (count_q),
        .dn (dn),
        .ci (1'b1),
        .s  (sum),
        .co (wrap)
    );

    cell_and u_sat (.a(wrap), .b(SAT_EN), .y(sat_hold));

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            cell_not  u_inv  (.a(count_q[i]), .y(count_n[i]));
            cell_mux2 u_step (.s(sat_hold), .a0(sum[i]),  .a1(count_q[i]), .y(step[i]));
            cell_mux2 u_en   (.s(en),       .a0(count_q[i]), .a1(step[i]),  .y(adv[i]));
            cell_mux2 u_load (.s(load),     .a0(adv[i]),  .a1(din[i]),     .y(nxt[i]));
        end
    endgenerate

    cell_or_tree #(.N(WIDTH)) u_any_one  (.a(count_q), .y(any_one));
    cell_or_tree #(.N(WIDTH)) u_any_zero (.a(count_n), .y(any_zero));
    cell_not                  u_is_zero  (.a(any_one),  .y(is_zero));
    cell_not                  u_is_ones  (.a(any_zero), .y(is_ones));

    cell_mux2    u_limit (.s(up), .a0(is_zero), .a1(is_ones), .y(at_limit));
    cell_and_not u_tc_nl (.a(at_limit), .b(load), .y(lim_nl));
    cell_and     u_tc    (.a(lim_nl), .b(en), .y(tc));

    always_comb begin
        count_d = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = is_zero;
endmodule

// File: tb/tb_cell_updown_counter.sv
// tb/tb_cell_updown_counter.sv - scoreboard bench for wrap/saturate 4-bit and wrap 9-bit counters
module tb_cell_updown_counter;
    logic       clk = 1'b0;
    logic       rst, en, load, up;
    logic [3:0] din4;
    logic [8:0] din9;
    logic [3:0] cnt_a, cnt_b;
    logic [8:0] cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       zero_a, zero_b, zero_c;

    always #5 clk = ~clk;

    cell_updown_counter #(.WIDTH(4), .SATURATE(0)) u_wrap4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up),
        .din(din4), .count(cnt_a), .tc(tc_a), .zero(zero_a)
    );
    cell_updown_counter #(.WIDTH(4), .SATURATE(1)) u_sat4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up),
        .din(din4), .count(cnt_b), .tc(tc_b), .zero(zero_b)
    );
    cell_updown_counter #(.WIDTH(9), .SATURATE(0)) u_wrap9 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up),
        .din(din9), .count(cnt_c), .tc(tc_c), .zero(zero_c)
    );

    typedef struct {
        int unit;
        int cnt;
        bit tc;
        bit zero;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   mdl[3]      = '{0, 0, 0};
    bit   mdl_ok      = 1'b0;
    int   wid[3]      = '{4, 4, 9};
    bit   sat[3]      = '{1'b0, 1'b1, 1'b0};

    function automatic int model_next(input int c, input int w, input bit s,
                                      input bit r, input bit e, input bit l, input bit u, input int d);
        int top;
        top = (1 << w) - 1;
        if (r) return 0;
        if (l) return d & top;
        if (!e) return c;
        if (u) begin
            if (c == top) return s ? top : 0;
            return c + 1;
        end
        if (c == 0) return s ? 0 : top;
        return c - 1;
    endfunction

    task automatic step(input bit r, input bit e, input bit l, input bit u, input int d4, input int d9);
        exp_t x;
        int   top;
        rst  = r;
        en   = e;
        load = l;
        up   = u;
        din4 = d4[3:0];
        din9 = d9[8:0];
        for (int k = 0; k < 3; k++) begin
            top = (1 << wid[k]) - 1;
            if (mdl_ok) begin
                x.unit = k;
                x.cnt  = mdl[k];
                x.tc   = e && !l && ((u && mdl[k] == top) || (!u && mdl[k] == 0));
                x.zero = (mdl[k] == 0);
                sbq.push_back(x);
            end
            mdl[k] = model_next(mdl[k], wid[k], sat[k], r, e, l, u, (k == 2) ? d9 : d4);
        end
        if (r) mdl_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        int   a_cnt;
        bit   a_tc, a_zero;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            case (x.unit)
                0:       begin a_cnt = int'(cnt_a); a_tc = tc_a; a_zero = zero_a; end
                1:       begin a_cnt = int'(cnt_b); a_tc = tc_b; a_zero = zero_b; end
                default: begin a_cnt = int'(cnt_c); a_tc = tc_c; a_zero = zero_c; end
            endcase
            vectors++;
            if (a_cnt != x.cnt || a_tc != x.tc || a_zero != x.zero) begin
                miscompares++;
                $display("FAIL unit%0d @%0t: got count=%0h tc=%0b zero=%0b, expected count=%0h tc=%0b zero=%0b",
                         x.unit, $time, a_cnt, a_tc, a_zero, x.cnt, x.tc, x.zero);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b0; din4 = '0; din9 = '0;

        // reset with counting requested, then count up three
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 1, 0, 0);

        // wrap/saturate around the top, then back down through zero
        step(0, 0, 1, 1, 'hE, 'h1FF);
        repeat (3) step(0, 1, 0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);

        step(0, 0, 1, 1, 'hF, 'h1FE);
        repeat (3) step(0, 1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 'h1, 'h1);
        repeat (3) step(0, 1, 0, 0, 0, 0);

        // priority: rst over load, load over en, then hold
        step(0, 0, 1, 1, 'h7, 'h7);
        step(1, 0, 1, 1, 'h9, 'h9);
        step(0, 1, 1, 1, 'h9, 'h9);
        step(0, 0, 0, 1, 'h9, 'h9);
        step(0, 0, 0, 0, 'h3, 'h3);

        // direction flip every edge
        step(0, 0, 1, 1, 'h5, 'h5);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 'hF : int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 'h1FF : int'($urandom_range(0, 511)));
        end

        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
